// File: rtl/datapath_pkg.sv
// Shared constants and encodings for the dual-lane register-file datapath.
package datapath_pkg;

  localparam int W    = 32;
  localparam int NREG = 16;
  localparam int AW   = 4;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SHL  = 3'd5,
    OP_SHR  = 3'd6,
    OP_PASS = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    VEC_32 = 2'b00,
    VEC_16 = 2'b01,
    VEC_8  = 2'b10,
    VEC_4  = 2'b11
  } vec_e;

  // Mask of the top bit of every lane; used to stop carries and borrows at lane edges.
  function automatic logic [W-1:0] lane_msb_mask(input vec_e lane);
    case (lane)
      VEC_16:  return 32'h8000_8000;
      VEC_8:   return 32'h8080_8080;
      VEC_4:   return 32'h8888_8888;
      default: return 32'h8000_0000;
    endcase
  endfunction

endpackage

// File: rtl/datapath_alu.sv
// One ALU lane: scalar or SIMD add/sub/logic/shift/pass with lane-isolated arithmetic.
module datapath_alu
  import datapath_pkg::*;
(
  input  logic [2:0]   op,
  input  logic         form,
  input  logic [1:0]   vec,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] r
);

  vec_e         lane;
  logic [W-1:0] h;
  logic [W-1:0] sum;
  logic [W-1:0] dif;
  logic [W-1:0] shl_r;
  logic [W-1:0] shr_r;

  assign lane = form ? vec_e'(vec) : VEC_32;
  assign h    = lane_msb_mask(lane);

  // Lane MSBs are excluded from the carry chain and repaired by XOR afterwards.
  assign sum = ((x & ~h) + (y & ~h)) ^ ((x ^ y) & h);
  assign dif = ((x | h) - (y & ~h)) ^ ((x ^ ~y) & h);

  always_comb begin
    shl_r = '0;
    shr_r = '0;
    case (lane)
      VEC_16: begin
        for (int i = 0; i < 2; i++) begin
          shl_r[i*16 +: 16] = x[i*16 +: 16] << y[i*16 +: 4];
          shr_r[i*16 +: 16] = x[i*16 +: 16] >> y[i*16 +: 4];
        end
      end
      VEC_8: begin
        for (int i = 0; i < 4; i++) begin
          shl_r[i*8 +: 8] = x[i*8 +: 8] << y[i*8 +: 3];
          shr_r[i*8 +: 8] = x[i*8 +: 8] >> y[i*8 +: 3];
        end
      end
      VEC_4: begin
        for (int i = 0; i < 8; i++) begin
          shl_r[i*4 +: 4] = x[i*4 +: 4] << y[i*4 +: 2];
          shr_r[i*4 +: 4] = x[i*4 +: 4] >> y[i*4 +: 2];
        end
      end
      default: begin
        shl_r = x << y[4:0];
        shr_r = x >> y[4:0];
      end
    endcase
  end

  always_comb begin
    case (alu_op_e'(op))
      OP_ADD:  r = sum;
      OP_SUB:  r = dif;
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      OP_SHL:  r = shl_r;
      OP_SHR:  r = shr_r;
      default: r = x;
    endcase
  end

endmodule

// File: rtl/datapath_core.sv
// Dual-issue execution core: 16x32 register file, four async read ports, two ALU lanes, two write ports.
module datapath_core
  import datapath_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    op,
  input  logic          form,
  input  logic [1:0]    vec,
  input  logic [AW-1:0] A,
  input  logic [AW-1:0] B,
  input  logic [AW-1:0] C,
  input  logic [AW-1:0] D,
  input  logic [3:0]    zero_reg,
  input  logic [AW-1:0] Y1,
  input  logic [AW-1:0] Y2,
  input  logic [1:0]    write,
  input  logic          const_a,
  input  logic [W-1:0]  constant
);

  logic [W-1:0] registers [0:NREG-1];

  logic [W-1:0] a_raw;
  logic [W-1:0] opa, opb, opc, opd;
  logic [W-1:0] r1, r2;

  // Zero mask is applied after the constant mux so it can also suppress the immediate.
  assign a_raw = const_a ? constant : registers[A];
  assign opa   = zero_reg[0] ? '0 : a_raw;
  assign opb   = zero_reg[1] ? '0 : registers[B];
  assign opc   = zero_reg[2] ? '0 : registers[C];
  assign opd   = zero_reg[3] ? '0 : registers[D];

  datapath_alu u_alu1 (
    .op   (op),
    .form (form),
    .vec  (vec),
    .x    (opa),
    .y    (opb),
    .r    (r1)
  );

  datapath_alu u_alu2 (
    .op   (op),
    .form (form),
    .vec  (vec),
    .x    (opc),
    .y    (opd),
    .r    (r2)
  );

  // Port 1 is written last so it wins when both ports target the same register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) registers[i] <= '0;
    end else begin
      if (write[1]) registers[Y2] <= r2;
      if (write[0]) registers[Y1] <= r1;
    end
  end

endmodule

// File: tb/tb_datapath_core.sv
// Directed-vector bench for datapath_core; expected values are hand-computed constants.
module tb_datapath_core;
  import datapath_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    op;
  logic          form;
  logic [1:0]    vec;
  logic [AW-1:0] A, B, C, D;
  logic [3:0]    zero_reg;
  logic [AW-1:0] Y1, Y2;
  logic [1:0]    write;
  logic          const_a;
  logic [W-1:0]  constant;

  int n_vec = 0;
  int n_err = 0;

  datapath_core dut (
    .clk      (clk),
    .rst      (rst),
    .op       (op),
    .form     (form),
    .vec      (vec),
    .A        (A),
    .B        (B),
    .C        (C),
    .D        (D),
    .zero_reg (zero_reg),
    .Y1       (Y1),
    .Y2       (Y2),
    .write    (write),
    .const_a  (const_a),
    .constant (constant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] i_op, input logic i_form, input logic [1:0] i_vec,
                       input logic [3:0] i_a, input logic [3:0] i_b,
                       input logic [3:0] i_c, input logic [3:0] i_d,
                       input logic [3:0] i_zr, input logic [3:0] i_y1, input logic [3:0] i_y2,
                       input logic [1:0] i_wr, input logic i_ca, input logic [31:0] i_k);
    op = i_op; form = i_form; vec = i_vec;
    A = i_a; B = i_b; C = i_c; D = i_d;
    zero_reg = i_zr; Y1 = i_y1; Y2 = i_y2;
    write = i_wr; const_a = i_ca; constant = i_k;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    op = 3'd0; form = 1'b0; vec = 2'b00;
    A = '0; B = '0; C = '0; D = '0;
    zero_reg = 4'b0000; Y1 = '0; Y2 = '0;
    write = 2'b00; const_a = 1'b0; constant = '0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREG; i++) chk($sformatf("reset_r%0d", i), dut.registers[i], 32'h0);

    // const 5 -> r1, const 7 -> r2
    issue(3'd0, 0, 2'b00, 0, 0, 0, 0, 4'b1110, 1, 0, 2'b01, 1, 32'd5);
    chk("const5_r1", dut.registers[1], 32'd5);
    issue(3'd0, 0, 2'b00, 0, 0, 0, 0, 4'b1110, 2, 0, 2'b01, 1, 32'd7);
    chk("const7_r2", dut.registers[2], 32'd7);
    chk("r1_kept", dut.registers[1], 32'd5);

    // write disabled: nothing changes
    issue(3'd0, 0, 2'b00, 1, 0, 2, 0, 4'b1010, 3, 3, 2'b00, 1, 32'd9);
    issue(3'd0, 0, 2'b00, 1, 0, 2, 0, 4'b1010, 3, 3, 2'b00, 0, 32'd11);
    issue(3'd0, 0, 2'b00, 1, 0, 2, 0, 4'b1010, 3, 3, 2'b00, 1, 32'd11);
    chk("nowr_r1", dut.registers[1], 32'd5);
    chk("nowr_r2", dut.registers[2], 32'd7);
    chk("nowr_r3", dut.registers[3], 32'd0);

    // port 2 sub: 7 - 5
    issue(3'd1, 0, 2'b00, 0, 0, 2, 1, 4'b0000, 0, 4, 2'b10, 0, 32'd0);
    chk("p2_sub_r4", dut.registers[4], 32'd2);
    chk("p2_r0_kept", dut.registers[0], 32'd0);

    // collision: R1 = 5-7, R2 = 7-5, port 1 wins
    issue(3'd1, 0, 2'b00, 1, 2, 2, 1, 4'b0000, 5, 5, 2'b11, 0, 32'd0);
    chk("collide_r5", dut.registers[5], 32'hFFFF_FFFE);

    // load SIMD operands via pass
    issue(3'd7, 0, 2'b00, 0, 0, 0, 0, 4'b0000, 6, 0, 2'b01, 1, 32'h00FF_00FF);
    issue(3'd7, 0, 2'b00, 0, 0, 0, 0, 4'b0000, 7, 0, 2'b01, 1, 32'h0001_0001);
    issue(3'd7, 0, 2'b00, 0, 0, 0, 0, 4'b0000, 10, 0, 2'b01, 1, 32'h0000_0021);
    chk("pass_r6", dut.registers[6], 32'h00FF_00FF);
    chk("pass_r7", dut.registers[7], 32'h0001_0001);

    // lane-isolated add / sub
    issue(3'd0, 1, 2'b01, 6, 7, 0, 0, 4'b0000, 8, 0, 2'b01, 0, 32'd0);
    chk("add_v16", dut.registers[8], 32'h0100_0100);
    issue(3'd0, 1, 2'b10, 6, 7, 0, 0, 4'b0000, 8, 0, 2'b01, 0, 32'd0);
    chk("add_v8", dut.registers[8], 32'h0000_0000);
    issue(3'd0, 1, 2'b11, 6, 7, 0, 0, 4'b0000, 8, 0, 2'b01, 0, 32'd0);
    chk("add_v4", dut.registers[8], 32'h00F0_00F0);
    issue(3'd0, 0, 2'b10, 6, 7, 0, 0, 4'b0000, 8, 0, 2'b01, 0, 32'd0);
    chk("add_scalar_vec_ignored", dut.registers[8], 32'h0100_0100);
    issue(3'd1, 1, 2'b01, 7, 6, 0, 0, 4'b0000, 8, 0, 2'b01, 0, 32'd0);
    chk("sub_v16", dut.registers[8], 32'hFF02_FF02);
    issue(3'd1, 0, 2'b00, 7, 6, 0, 0, 4'b0000, 8, 0, 2'b01, 0, 32'd0);
    chk("sub_scalar", dut.registers[8], 32'hFF01_FF02);
    issue(3'd1, 1, 2'b10, 7, 6, 0, 0, 4'b0000, 8, 0, 2'b01, 0, 32'd0);
    chk("sub_v8", dut.registers[8], 32'h0002_0002);

    // shifts
    issue(3'd5, 0, 2'b00, 6, 4, 0, 0, 4'b0000, 8, 0, 2'b01, 0, 32'd0);
    chk("shl_scalar", dut.registers[8], 32'h03FC_03FC);
    issue(3'd5, 1, 2'b10, 6, 7, 0, 0, 4'b0000, 8, 0, 2'b01, 0, 32'd0);
    chk("shl_v8", dut.registers[8], 32'h00FE_00FE);
    issue(3'd6, 1, 2'b11, 6, 7, 0, 0, 4'b0000, 8, 0, 2'b01, 0, 32'd0);
    chk("shr_v4", dut.registers[8], 32'h00F7_00F7);
    issue(3'd6, 0, 2'b00, 6, 7, 0, 0, 4'b0000, 8, 0, 2'b01, 0, 32'd0);
    chk("shr_scalar", dut.registers[8], 32'h007F_807F);
    issue(3'd5, 0, 2'b00, 0, 10, 0, 0, 4'b0000, 8, 0, 2'b01, 1, 32'd1);
    chk("shl_amt_masked", dut.registers[8], 32'h0000_0002);

    // logic ops on port 2, SIMD form has no effect
    issue(3'd4, 1, 2'b11, 0, 0, 6, 7, 4'b0000, 0, 9, 2'b10, 0, 32'd0);
    chk("xor_p2", dut.registers[9], 32'h00FE_00FE);
    issue(3'd3, 1, 2'b01, 0, 0, 6, 7, 4'b0000, 0, 9, 2'b10, 0, 32'd0);
    chk("or_p2", dut.registers[9], 32'h00FF_00FF);
    issue(3'd2, 0, 2'b00, 0, 0, 6, 7, 4'b0000, 0, 9, 2'b10, 0, 32'd0);
    chk("and_p2", dut.registers[9], 32'h0001_0001);

    // read-then-write same register: both lanes see pre-edge r1
    issue(3'd0, 0, 2'b00, 1, 1, 1, 0, 4'b0000, 1, 11, 2'b11, 0, 32'd0);
    chk("rmw_r1", dut.registers[1], 32'd10);
    chk("rmw_r11_old", dut.registers[11], 32'd5);

    // zero mask overrides the constant
    issue(3'd7, 0, 2'b00, 0, 0, 0, 0, 4'b0001, 1, 0, 2'b01, 1, 32'hDEAD_BEEF);
    chk("zero_after_const", dut.registers[1], 32'd0);

    // reset wins over a pending write
    rst = 1'b1;
    issue(3'd7, 0, 2'b00, 0, 0, 0, 0, 4'b0000, 2, 0, 2'b01, 1, 32'h1234_5678);
    rst = 1'b0;
    chk("rst2_r2", dut.registers[2], 32'd0);
    chk("rst2_r6", dut.registers[6], 32'd0);
    chk("rst2_r9", dut.registers[9], 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/datapath_core.md
Name: datapath_core

Overview:
- Dual-issue register-file datapath: 16 x 32-bit registers, two ALU lanes, two write ports.
- Each cycle reads four operands (A, B, C, D) and computes R1 = op(A', B') and R2 = op(C', D').
- On the rising clock edge, optionally writes R1 to register Y1 and R2 to register Y2.
- Sits between the instruction decoder, which drives all controls, and nothing else; purely an execution core.

Parameters:
- NREG, 16, number of registers (address width 4).
- W, 32, register and data width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- op  in  3  ALU operation, shared by both lanes.
- form  in  1  0 = scalar 32-bit op; 1 = SIMD op, lane size set by vec.
- vec  in  2  SIMD lane size when form=1: 00=32, 01=16, 10=8, 11=4 bits.
- A  in  4  read address, operand A.
- B  in  4  read address, operand B.
- C  in  4  read address, operand C.
- D  in  4  read address, operand D.
- zero_reg  in  4  per-operand zero mask: bit0=A, bit1=B, bit2=C, bit3=D; 1 forces that operand to 0.
- Y1  in  4  write address for R1.
- Y2  in  4  write address for R2.
- write  in  2  bit0 enables R1->Y1; bit1 enables R2->Y2.
- const_a  in  1  1 replaces the register value of operand A with constant.
- constant  in  32  immediate for operand A.
- Internal state: registers[0:15], 32 bits each. Hierarchically visible under the name "registers"; the verification bench reads it.

Behaviour:
- Reset: clk and rst are as already decided (one clock; reset synchronous, active-high). With rst=1 at a posedge, all 16 registers clear to 0; no writes occur that cycle.
- Operand formation (combinational):
  - a = const_a ? constant : registers[A]; b = registers[B]; c = registers[C]; d = registers[D].
  - Then each operand is zeroed if its zero_reg bit is set.
  - The zero mask applies after the constant mux.
- ALU ops, identical for both lanes:
  - 0 add, 1 sub (x-y), 2 and, 3 or, 4 xor.
  - 5 shl x by y, 6 logical shr x by y; shift amount = low log2(lane) bits of y.
  - 7 pass x.
- form=1: add, sub and shift operate independently per lane; no carry or borrow crosses lanes; results wrap modulo 2^lane. Logic ops and pass are lane-agnostic.
- form=0: vec is ignored; 32-bit wrap-around.
- Writes occur at posedge only:
  - write[0] -> registers[Y1] <= R1.
  - write[1] -> registers[Y2] <= R2.
  - write=00 -> register file unchanged regardless of other inputs.
- Collision: Y1==Y2 with both enables set -> R1 (port 1) wins.
- Register 0 is an ordinary writable register (no hardwired zero; use zero_reg for zeros).
- Reads are asynchronous and show pre-edge contents. Reading and writing the same register in one cycle returns the old value; there is no bypass.
- Latency: result visible in the register file one edge after inputs are stable.

Decomposition:
- Shared package holds:
  - op encodings (OP_ADD..OP_PASS);
  - vec lane encodings;
  - the W and NREG constants.
- One sub-module, datapath_alu (op, form, vec, x, y -> r), instantiated twice.
- Register file and operand muxing stay in datapath_core.

Test Plan:
1. Reset for 1 cycle, then read -> all registers 0.
2. zero_reg=1110, op=0, const_a=1, constant=5, Y1=1, write=01, one edge -> registers[1]=5.
3. Repeat scenario 2 with Y1=2, constant=7 -> registers[2]=7, registers[1] still 5.
4. write=00, zero_reg=1010, A=1, C=2, Y1=3, const_a toggled 1/0 with constant=9 then 11, several edges -> registers 1/2/3 stay 5/7/0.
5. Lane 2, second port: registers[1]=5, registers[2]=7, zero_reg=0000, op=1 (sub), C=2, D=1, Y2=4, write=10 -> registers[4]=2. Then a collision cycle: Y1=Y2=5, write=11 -> registers[5] holds R1.
6. SIMD: registers holding 0x00FF00FF + 0x00010001 with form=1, vec=01, op=0 -> 0x01000100. Same inputs with vec=10 -> 0x00000000 (no carry between 8-bit lanes).
